pov_frame_sequencer: RTL and testbench

Frame and angle sequencer for the LED-fan POV display. Turns the raw `fanclk` step pulses into a clean degree index (360 down to 1) plus a revolution tick. Selects which of up to `NUM_FRAMES` pattern frames the downstream LED pattern decoders render, advancing automatically every `REVS_PER_FRAME` revolutions or on a user button. Blanks the LEDs during spin-up and when the fan stalls, so pattern logic never paints garbage at an invalid angle.

---
 rtl/pov_frame_sequencer_if.sv | 34 +++
 rtl/pov_frame_sequencer.sv | 175 +++++++++++++++++
 tb/tb_pov_frame_sequencer.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pov_frame_sequencer_if.sv
// Signal bundle between the POV frame sequencer and its environment.
// The index sensor line exists only when SEQ_INDEX_SYNC_EN is defined.
interface pov_frame_sequencer_if;
    logic       fanclk;
    logic       btn_next;
    logic       auto_en;
`ifdef SEQ_INDEX_SYNC_EN
    logic       index;
`endif
    logic [8:0] deg;
    logic [2:0] frame;
    logic       blank;
    logic       rev_tick;

`ifdef SEQ_INDEX_SYNC_EN
    modport master (
        output fanclk, btn_next, auto_en, index,
        input  deg, frame, blank, rev_tick
    );
    modport slave (
        input  fanclk, btn_next, auto_en, index,
        output deg, frame, blank, rev_tick
    );
`else
    modport master (
        output fanclk, btn_next, auto_en,
        input  deg, frame, blank, rev_tick
    );
    modport slave (
        input  fanclk, btn_next, auto_en,
        output deg, frame, blank, rev_tick
    );
`endif
endinterface

// File: rtl/pov_frame_sequencer.sv
// Degree/frame sequencer for the LED-fan POV display: degree index, revolution tick,
// frame selection and blanking. Define SEQ_INDEX_SYNC_EN to resync revolutions on the index sensor.
module pov_frame_sequencer #(
    parameter int NUM_FRAMES     = 8,
    parameter int REVS_PER_FRAME = 4,
    parameter int STALL_CYCLES   = 1_000_000
) (
    input  logic                    clk,
    input  logic                    rst,
    pov_frame_sequencer_if.slave    bus
);

    typedef enum logic [1:0] {
        SPINUP = 2'd0,
        RUN    = 2'd1,
        STALL  = 2'd2
    } state_t;

    localparam int              SW         = $clog2(STALL_CYCLES);
    localparam logic [SW-1:0]   STALL_MAX  = SW'(STALL_CYCLES - 1);
    localparam logic [SW-1:0]   STALL_ONE  = SW'(1);
    localparam logic [2:0]      LAST_FRAME = 3'(NUM_FRAMES - 1);
    localparam logic [7:0]      LAST_REV   = 8'(REVS_PER_FRAME - 1);

    state_t         state;
    state_t         state_next;

    logic           fan_q;
    logic           btn_q;
    logic           fan_edge;
    logic           btn_edge;
`ifdef SEQ_INDEX_SYNC_EN
    logic           idx_q;
    logic           idx_edge;
`endif

    logic [8:0]     deg;
    logic [8:0]     deg_next;
    logic [8:0]     deg_step;
    logic [2:0]     frame;
    logic [2:0]     frame_next;
    logic           rev_tick;
    logic           pending;
    logic           pending_next;
    logic [7:0]     rev_cnt;
    logic [7:0]     rev_cnt_next;
    logic [SW-1:0]  stall_cnt;
    logic [SW-1:0]  stall_cnt_next;

    logic           boundary;
    logic           stall_hit;
    logic           tick_run;
    logic           auto_adv;
    logic           advance;

    assign fan_edge = bus.fanclk & ~fan_q;
    assign btn_edge = bus.btn_next & ~btn_q;
`ifdef SEQ_INDEX_SYNC_EN
    assign idx_edge = bus.index & ~idx_q;
`endif

    assign deg_step  = (deg == 9'd1) ? 9'd360 : deg - 9'd1;
    assign stall_hit = (stall_cnt == STALL_MAX);

    // Degree stepping and boundary detection; in STALL a fan edge still steps but never marks a boundary.
    always_comb begin
        deg_next = deg;
        boundary = 1'b0;
`ifdef SEQ_INDEX_SYNC_EN
        if ((state != STALL) && idx_edge) begin
            deg_next = 9'd360;
            boundary = 1'b1;
        end else if (fan_edge) begin
            deg_next = deg_step;
        end
`else
        if (fan_edge) begin
            deg_next = deg_step;
            boundary = (state != STALL) && (deg == 9'd1);
        end
`endif
    end

    always_comb begin
        state_next = state;
        case (state)
            SPINUP: begin
                if (boundary) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (!boundary && !fan_edge && stall_hit) begin
                    state_next = STALL;
                end
            end
            STALL: begin
                if (fan_edge) begin
                    state_next = SPINUP;
                end
            end
            default: state_next = SPINUP;
        endcase
    end

    // Frame advance is decided on the boundary itself so frame and rev_tick change together.
    always_comb begin
        tick_run     = boundary && (state == RUN);
        auto_adv     = tick_run && bus.auto_en && (rev_cnt == LAST_REV);
        advance      = tick_run && (pending || auto_adv);

        frame_next   = frame;
        pending_next = pending | btn_edge;
        rev_cnt_next = rev_cnt;

        if (advance) begin
            frame_next   = (frame == LAST_FRAME) ? 3'd0 : frame + 3'd1;
            pending_next = btn_edge;
        end

        if (!bus.auto_en || advance) begin
            rev_cnt_next = 8'd0;
        end else if (tick_run) begin
            rev_cnt_next = rev_cnt + 8'd1;
        end

        if (fan_edge) begin
            stall_cnt_next = '0;
        end else if (stall_hit) begin
            stall_cnt_next = stall_cnt;
        end else begin
            stall_cnt_next = stall_cnt + STALL_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SPINUP;
            fan_q     <= 1'b0;
            btn_q     <= 1'b0;
            deg       <= 9'd360;
            frame     <= 3'd0;
            rev_tick  <= 1'b0;
            pending   <= 1'b0;
            rev_cnt   <= 8'd0;
            stall_cnt <= '0;
        end else begin
            state     <= state_next;
            fan_q     <= bus.fanclk;
            btn_q     <= bus.btn_next;
            deg       <= deg_next;
            frame     <= frame_next;
            rev_tick  <= boundary;
            pending   <= pending_next;
            rev_cnt   <= rev_cnt_next;
            stall_cnt <= stall_cnt_next;
        end
    end

`ifdef SEQ_INDEX_SYNC_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= 1'b0;
        end else begin
            idx_q <= bus.index;
        end
    end
`endif

    assign bus.deg      = deg;
    assign bus.frame    = frame;
    assign bus.rev_tick = rev_tick;
    assign bus.blank    = (state != RUN);

endmodule

// File: tb/tb_pov_frame_sequencer.sv
// Randomized scoreboard bench for pov_frame_sequencer; a revolution-level model
// predicts degree, frame and blanking, and a monitor checks every rev_tick.
module tb_pov_frame_sequencer;

    localparam int NF  = 8;
    localparam int RPF = 4;
    localparam int SC  = 16;

    typedef enum {M_SPIN, M_RUN, M_STALL} mode_t;

    logic clk = 1'b0;
    logic rst;
    logic auto_lvl;

    always #5 clk = ~clk;

    pov_frame_sequencer_if bus ();

    pov_frame_sequencer #(
        .NUM_FRAMES     (NF),
        .REVS_PER_FRAME (RPF),
        .STALL_CYCLES   (SC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int    checks = 0;
    int    passes = 0;
    int    ticks_seen = 0;
    int    m_ticks = 0;
    int    exp_q[$];

    int    m_deg;
    int    m_frame;
    int    m_revs;
    int    m_idle;
    logic  m_pending;
    mode_t m_mode;
    logic  m_fan_q;
    logic  m_btn_q;
    logic  m_idx_q;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic int stepDeg(input int d);
        return (d == 1) ? 360 : d - 1;
    endfunction

    // Reference model: one call per clock, predicting the state right after the coming edge.
    task automatic modelCycle(input logic r, input logic fan, input logic btn,
                              input logic idx, input logic au);
        logic fe;
        logic be;
        logic ie;
        logic bnd;
        logic adv;
        if (r) begin
            m_deg = 360; m_frame = 0; m_revs = 0; m_idle = 0;
            m_pending = 1'b0; m_mode = M_SPIN;
            m_fan_q = 1'b0; m_btn_q = 1'b0; m_idx_q = 1'b0;
            exp_q.delete();
            return;
        end
        fe  = fan & ~m_fan_q;
        be  = btn & ~m_btn_q;
        ie  = idx & ~m_idx_q;
        bnd = 1'b0;
        adv = 1'b0;
        if (m_mode == M_STALL) begin
            if (fe) begin
                m_deg  = stepDeg(m_deg);
                m_mode = M_SPIN;
            end
        end else begin
`ifdef SEQ_INDEX_SYNC_EN
            if (ie) begin
                m_deg = 360;
                bnd   = 1'b1;
            end else if (fe) begin
                m_deg = stepDeg(m_deg);
            end
`else
            if (fe) begin
                bnd   = (m_deg == 1);
                m_deg = stepDeg(m_deg);
            end
`endif
            if (bnd && m_mode == M_SPIN) begin
                m_mode = M_RUN;
            end else if (bnd) begin
                if (au) m_revs++;
                adv = m_pending || (au && m_revs == RPF);
                if (adv) begin
                    m_frame = (m_frame + 1) % NF;
                    m_revs  = 0;
                end
            end else if (m_mode == M_RUN && !fe && m_idle == SC - 1) begin
                m_mode = M_STALL;
            end
            if (bnd) begin
                exp_q.push_back(m_frame);
                m_ticks++;
            end
        end
        m_pending = adv ? be : (m_pending | be);
        if (!au) m_revs = 0;
        m_idle  = fe ? 0 : ((m_idle == SC - 1) ? m_idle : m_idle + 1);
        m_fan_q = fan;
        m_btn_q = btn;
        m_idx_q = ie ? idx : idx;
    endtask

    task automatic applyStimulus(input logic r, input logic fan, input logic btn, input logic idx);
        rst          = r;
        bus.fanclk   = fan;
        bus.btn_next = btn;
        bus.auto_en  = auto_lvl;
`ifdef SEQ_INDEX_SYNC_EN
        bus.index    = idx;
`endif
        modelCycle(r, fan, btn, idx, auto_lvl);
        @(negedge clk);
        checkOutput("deg", int'(bus.deg), m_deg);
        checkOutput("frame", int'(bus.frame), m_frame);
        checkOutput("blank", int'(bus.blank), int'(m_mode != M_RUN));
    endtask

    // Each step: fan high (sometimes held two cycles), then 1..3 low cycles with optional button/index pulses.
    task automatic doSteps(input int n, input int press_a, input int press_b, input int permille);
        for (int i = 0; i < n; i++) begin
            int   gap;
            logic press;
            logic idx;
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
            if ($urandom_range(0, 7) == 0) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
            press = (m_deg == press_a) || (m_deg == press_b) ||
                    ($urandom_range(0, 999) < permille);
`ifdef SEQ_INDEX_SYNC_EN
            idx = (m_deg == 1);
`else
            idx = 1'b0;
`endif
            gap = $urandom_range(1, 3);
            if ((press || idx) && gap < 2) gap = 2;
            for (int g = 0; g < gap; g++) begin
                applyStimulus(1'b0, 1'b0, press && (g == 0), idx && (g == 0));
            end
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (!rst && bus.rev_tick) begin
            ticks_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                $display("[TB] FAIL unexpected_tick: rev_tick high at deg %0d, none expected", bus.deg);
            end else begin
                int e;
                e = exp_q.pop_front();
                checkOutput("tick_frame", int'(bus.frame), e);
                checkOutput("tick_deg", int'(bus.deg), 360);
                checkOutput("tick_blank", int'(bus.blank), 0);
            end
        end
    end

    initial begin
        auto_lvl = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("reset_deg", int'(bus.deg), 360);
        checkOutput("reset_frame", int'(bus.frame), 0);
        checkOutput("reset_blank", int'(bus.blank), 1);
        checkOutput("reset_rev_tick", int'(bus.rev_tick), 0);

        doSteps(360, -1, -1, 0);
        checkOutput("spinup_exit_blank", int'(bus.blank), 0);
        checkOutput("spinup_ticks", ticks_seen, 1);

        auto_lvl = 1'b1;
        doSteps(360 * 32, -1, -1, 0);
        checkOutput("auto_full_cycle_frame", int'(bus.frame), 0);

        auto_lvl = 1'b0;
        doSteps(360, 180, 90, 0);
        checkOutput("two_presses_one_advance", int'(bus.frame), 1);

        auto_lvl = 1'b1;
        doSteps(360 * 3, -1, -1, 0);
        checkOutput("auto_before_fourth", int'(bus.frame), 1);
        doSteps(360, 50, -1, 0);
        checkOutput("btn_plus_auto_once", int'(bus.frame), 2);
        doSteps(360 * 3, -1, -1, 0);
        checkOutput("revcnt_cleared", int'(bus.frame), 2);
        doSteps(360, -1, -1, 0);
        checkOutput("auto_after_clear", int'(bus.frame), 3);

        auto_lvl = 1'b0;
        doSteps(100, -1, -1, 0);
        for (int g = 0; g < 20; g++) applyStimulus(1'b0, 1'b0, g == 5, 1'b0);
        checkOutput("stall_blank", int'(bus.blank), 1);
        checkOutput("stall_deg_frozen", int'(bus.deg), 260);
        doSteps(1, -1, -1, 0);
        checkOutput("restart_blank", int'(bus.blank), 1);
        checkOutput("restart_deg", int'(bus.deg), 259);
        doSteps(259, -1, -1, 0);
        checkOutput("respin_no_advance", int'(bus.frame), 3);
        doSteps(360, -1, -1, 0);
        checkOutput("pending_survives_stall", int'(bus.frame), 4);

        for (int r = 0; r < 4; r++) begin
            auto_lvl = logic'($urandom_range(0, 1));
            doSteps(360, -1, -1, 4);
        end

        auto_lvl = 1'b0;
        doSteps(100, -1, -1, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("midrev_reset_deg", int'(bus.deg), 360);
        checkOutput("midrev_reset_frame", int'(bus.frame), 0);
        doSteps(720, -1, -1, 0);
        checkOutput("reset_drops_pending", int'(bus.frame), 0);

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("tick_count", ticks_seen, m_ticks);
        checkOutput("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
